// File: rtl/clk_monitor.sv
// Samples an asynchronous toggle/clock with clk, measures its period and high time,
// tracks lock against an expected period and flags deviations and stuck inputs.
module clk_monitor #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned EXP_PERIOD  = 100,
  parameter int unsigned TOL         = 2,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned TIMEOUT     = 1000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_in,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             period_valid,
  output logic             locked,
  output logic             err_period,
  output logic             err_stuck,
  output logic [31:0]      edge_count
);

  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] PerLo   = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0] PerHi   = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] TmoLast = CNT_W'(TIMEOUT - 1);
  localparam logic [GW-1:0]    LockCnt = GW'(LOCK_COUNT);

  typedef enum logic [1:0] {StIdle, StMeasure, StLocked} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CNT_W-1:0]       period_q, period_d, high_q, high_d;
  logic [GW-1:0]          good_q, good_d;
  logic                   valid_q, valid_d, locked_q, locked_d;
  logic                   errp_q, errp_d, stuck_q, stuck_d;
  logic [31:0]            edges_q, edges_d;

  logic             s, rise, fall, is_good, errp_set, stuck_set;
  logic [CNT_W-1:0] meas;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d_q;
  assign fall    = ~s & s_d_q;
  // cnt is cleared on the rise cycle itself, so the period is one more than its value.
  assign meas    = cnt_q + CNT_W'(1);
  assign is_good = (meas >= PerLo) && (meas <= PerHi);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    good_d    = good_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    edges_d   = edges_q;
    errp_set  = 1'b0;
    stuck_set = 1'b0;

    if (state_q != StIdle && cnt_q != CntMax) cnt_d = cnt_q + CNT_W'(1);
    if (s && hcnt_q != CntMax) hcnt_d = hcnt_q + CNT_W'(1);
    if (fall) high_d = hcnt_q + CNT_W'(1);

    if (rise) begin
      cnt_d   = '0;
      hcnt_d  = '0;
      edges_d = edges_q + 32'd1;
      case (state_q)
        StIdle: begin
          state_d = StMeasure;
          good_d  = '0;
        end
        StMeasure: begin
          valid_d  = 1'b1;
          period_d = meas;
          if (is_good) begin
            good_d = GW'(good_q + 1'b1);
            if (GW'(good_q + 1'b1) == LockCnt) begin
              state_d  = StLocked;
              locked_d = 1'b1;
            end
          end else begin
            good_d = '0;
          end
        end
        StLocked: begin
          valid_d  = 1'b1;
          period_d = meas;
          if (!is_good) begin
            errp_set = 1'b1;
            locked_d = 1'b0;
            good_d   = '0;
            state_d  = StMeasure;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && cnt_q == TmoLast) begin
      stuck_set = 1'b1;
      locked_d  = 1'b0;
      good_d    = '0;
      state_d   = StIdle;
    end

    // A new error outranks a simultaneous clear.
    errp_d  = errp_set | (errp_q & ~err_clr);
    stuck_d = stuck_set | (stuck_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      s_d_q    <= 1'b0;
      state_q  <= StIdle;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      good_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      errp_q   <= 1'b0;
      stuck_q  <= 1'b0;
      edges_q  <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], mon_in};
      s_d_q    <= s;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      good_q   <= good_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      errp_q   <= errp_d;
      stuck_q  <= stuck_d;
      edges_q  <= edges_d;
    end
  end

  assign period_out   = period_q;
  assign high_out     = high_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign err_period   = errp_q;
  assign err_stuck    = stuck_q;
  assign edge_count   = edges_q;

endmodule

// File: tb/tb_clk_monitor.sv
// Bench for clk_monitor: mon_in is built from high/low segments and compared against an
// event-level model that works on rise-to-rise intervals rather than per-cycle state.
module tb_clk_monitor;

  localparam int unsigned CNT_W = 16;
  localparam int          EXP   = 100;
  localparam int          TOL   = 2;
  localparam int          LOCKN = 4;
  localparam int          TMO   = 1000;
  localparam int          SYNC  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             mon_in = 1'b0;
  logic             err_clr = 1'b0;
  logic [CNT_W-1:0] period_out, high_out;
  logic             period_valid, locked, err_period, err_stuck;
  logic [31:0]      edge_count;

  always #5 clk = ~clk;

  clk_monitor #(
    .CNT_W       (CNT_W),
    .EXP_PERIOD  (EXP),
    .TOL         (TOL),
    .LOCK_COUNT  (LOCKN),
    .TIMEOUT     (TMO),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mon_in       (mon_in),
    .err_clr      (err_clr),
    .period_out   (period_out),
    .high_out     (high_out),
    .period_valid (period_valid),
    .locked       (locked),
    .err_period   (err_period),
    .err_stuck    (err_stuck),
    .edge_count   (edge_count)
  );

  typedef struct {
    int          per;
    int          hi;
    bit          lck;
    bit          ep;
    logic [31:0] edges;
  } exp_t;

  exp_t expq[$];

  int checks   = 0;
  int failures = 0;

  bit          m_started, m_locked, m_errp, m_stuck;
  int          m_good, m_last_t, m_last_hi, cyc;
  logic [31:0] m_edges;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Every reported period must match the oldest outstanding model event.
  exp_t e;
  always @(negedge clk) begin
    if (period_valid === 1'b1) begin
      if (expq.size() == 0) begin
        check_eq("spurious_valid", 32'(period_valid), 32'd0);
      end else begin
        e = expq.pop_front();
        check_eq("period_out", 32'(period_out), 32'(e.per));
        check_eq("high_out", 32'(high_out), 32'(e.hi));
        check_eq("locked_at_valid", 32'(locked), 32'(e.lck));
        check_eq("err_period_at_valid", 32'(err_period), 32'(e.ep));
        check_eq("edge_count", edge_count, e.edges);
      end
    end
  end

  task automatic model_reset();
    m_started = 0; m_locked = 0; m_errp = 0; m_stuck = 0;
    m_good = 0; m_last_t = 0; m_last_hi = 0; m_edges = '0;
  endtask

  // One mon_in rise as seen by the monitor; clr_now means err_clr lands on the same update.
  task automatic model_rise(input bit clr_now);
    bit   new_err = 0;
    bit   report = 0;
    bit   good;
    int   p;
    exp_t x;
    m_edges = m_edges + 32'd1;
    if (!m_started) begin
      m_started = 1;
      m_good    = 0;
    end else begin
      report = 1;
      p      = cyc - m_last_t;
      good   = (p >= EXP - TOL) && (p <= EXP + TOL);
      if (m_locked) begin
        if (!good) begin
          new_err  = 1;
          m_locked = 0;
          m_good   = 0;
        end
      end else if (good) begin
        m_good++;
        if (m_good >= LOCKN) m_locked = 1;
      end else begin
        m_good = 0;
      end
      x.per = p;
    end
    if (clr_now) begin
      m_errp  = 0;
      m_stuck = 0;
    end
    if (new_err) m_errp = 1;
    if (report) begin
      x.hi    = m_last_hi;
      x.lck   = m_locked;
      x.ep    = m_errp;
      x.edges = m_edges;
      expq.push_back(x);
    end
    m_last_t = cyc;
  endtask

  // One mon_in pulse: hi cycles high then lo cycles low; err_clr pulses on segment cycle clr_idx.
  task automatic drive(input int hi, input int lo, input int clr_idx);
    for (int i = 0; i < hi + lo; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (m_started && i == SYNC + TMO) begin
        check_eq("pre_stuck", 32'(err_stuck), 32'(m_stuck));
        check_eq("pre_stuck_locked", 32'(locked), 32'(m_locked));
      end
      if (m_started && i == SYNC + TMO + 1) begin
        m_stuck = 1; m_locked = 0; m_started = 0; m_good = 0;
        check_eq("err_stuck", 32'(err_stuck), 32'd1);
        check_eq("stuck_locked", 32'(locked), 32'd0);
      end
      mon_in  = (i < hi);
      err_clr = (i == clr_idx);
      if (i == SYNC) begin
        model_rise(clr_idx == SYNC);
      end else if (i == clr_idx) begin
        m_errp  = 0;
        m_stuck = 0;
      end
    end
    m_last_hi = hi;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_locked"}, 32'(locked), 32'(m_locked));
    check_eq({tag, "_err_period"}, 32'(err_period), 32'(m_errp));
    check_eq({tag, "_err_stuck"}, 32'(err_stuck), 32'(m_stuck));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    cyc++;
    rst     = 1'b1;
    mon_in  = 1'b0;
    err_clr = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    check_eq("rst_period_out", 32'(period_out), 32'd0);
    check_eq("rst_high_out", 32'(high_out), 32'd0);
    check_eq("rst_period_valid", 32'(period_valid), 32'd0);
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_err_period", 32'(err_period), 32'd0);
    check_eq("rst_err_stuck", 32'(err_stuck), 32'd0);
    check_eq("rst_edge_count", edge_count, 32'd0);
    check_eq("pending_at_reset", 32'(expq.size()), 32'd0);
    rst = 1'b0;
    model_reset();
    expq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int p, hi;
    cyc = 0;
    model_reset();
    do_reset();

    repeat (6) drive(50, 50, -1);
    check_state("lock50");

    repeat (4) begin
      p  = int'($urandom_range(EXP + TOL, EXP - TOL));
      hi = int'($urandom_range(70, 20));
      drive(hi, p - hi, -1);
    end
    check_state("in_tol");

    drive(52, 52, -1);
    check_state("bad104");
    repeat (5) drive(50, 50, -1);
    check_state("relock");

    drive(50, 50, 70);
    check_state("clr_alone");
    drive(52, 52, SYNC);
    check_state("clr_with_err");

    repeat (5) drive(30, 70, -1);
    check_state("duty30");

    drive(50, 1200, -1);
    check_state("stuck");
    repeat (6) drive(50, 50, -1);
    check_state("after_stuck");
    drive(50, 50, 70);
    check_state("clr_stuck");

    drive(50, 20, -1);
    do_reset();
    repeat (6) drive(50, 50, -1);
    check_state("after_rst");

    repeat (20) begin
      p  = int'($urandom_range(106, 94));
      hi = int'($urandom_range(p - 1, 1));
      drive(hi, p - hi, ($urandom_range(3, 0) == 0) ? int'($urandom_range(p - 1, 0)) : -1);
    end
    check_state("random");

    drive(50, 50, -1);
    repeat (5) @(posedge clk);
    #1;
    check_eq("pending_at_end", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
